// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poller.
// Button bit order matches the controller's serial shift order.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int DIV_DEFAULT = 6;
  localparam int PH_W        = 9;

endpackage

// File: rtl/nes_phase_timer.sv
// Reloadable phase down-counter; o_tc flags the final cycle
// of the currently loaded phase.
module nes_phase_timer
  import nes_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic [PH_W-1:0] i_load_val,
  output logic            o_tc
);

  logic [PH_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/nes_poll_controller.sv
// NES controller poller: latch/clock sequencing, serial capture,
// edge detection and optional periodic auto-polling.
module nes_poll_controller
  import nes_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter int POLL_PERIOD = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       poll_req,
  input  logic       auto_en,
  input  logic       dataYellow,
  output logic       latchOrange,
  output logic       clockRed,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid,
  output logic       busy
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [PH_W-1:0] LATCH_LD = PH_W'(2*DIV-1);
  localparam logic [PH_W-1:0] PHASE_LD = PH_W'(DIV-1);
  localparam logic [TW-1:0]   TMR_LAST = TW'(POLL_PERIOD-1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic            r_pending;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_buttons;
  logic [7:0]      r_pressed;
  logic            r_valid;

  logic            w_tick;
  logic            w_start;
  logic            w_load;
  logic [PH_W-1:0] w_load_val;
  logic            w_sample;
  logic            w_fin;
  logic            w_tc;
  logic [7:0]      w_shift_nxt;

  nes_phase_timer u_phase (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  assign w_tick  = auto_en && (r_timer == TMR_LAST);
  assign w_start = poll_req | w_tick;

  assign w_shift_nxt = {r_shift[BTN_A-1:BTN_RIGHT], dataYellow};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (!auto_en || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = PHASE_LD;
    w_sample    = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start || r_pending) begin
          w_state_nxt = LATCH;
          w_load      = 1'b1;
          w_load_val  = LATCH_LD;
        end
      end
      LATCH: begin
        if (w_tc) begin
          w_sample    = 1'b1;
          w_state_nxt = CLK_HI;
          w_load      = 1'b1;
        end
      end
      CLK_HI: begin
        if (w_tc) begin
          w_state_nxt = CLK_LO;
          w_load      = 1'b1;
        end
      end
      CLK_LO: begin
        if (w_tc) begin
          w_sample = 1'b1;
          if (r_bit_cnt == 3'd6) begin
            w_fin       = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = CLK_HI;
            w_load      = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A request arriving mid-read is remembered once and
  // consumed as soon as the FSM is back in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == IDLE) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift   <= 8'hFF;
      r_bit_cnt <= 3'd0;
    end else begin
      if (w_sample) begin
        r_shift <= w_shift_nxt;
      end
      if (r_state == IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sample && (r_state == CLK_LO)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Results load as DONE is entered so valid and the new
  // data appear together during the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buttons <= 8'h00;
      r_pressed <= 8'h00;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_fin;
      if (w_fin) begin
        r_buttons <= ~w_shift_nxt;
        r_pressed <= ~w_shift_nxt & ~r_buttons;
      end
    end
  end

  assign latchOrange = (r_state == LATCH);
  assign clockRed    = (r_state == CLK_HI);
  assign busy        = (r_state != IDLE);
  assign buttons     = r_buttons;
  assign pressed     = r_pressed;
  assign valid       = r_valid;

endmodule
